// File: rtl/audio_pkg.sv
// audio_pkg: shared receiver state, channel and width definitions
package audio_pkg;
  localparam int SAMPLE_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, PAD} rx_state_t;
  typedef enum logic {CH_LEFT, CH_RIGHT} channel_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-stage synchroniser with a rising-edge strobe on the clock-like input
module sync_edge_detect #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             edge_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             rise_o
);
  logic [STAGES-1:0][WIDTH:0] sync_q;
  logic                       prev_q;
  // Shift raw inputs through the chain; keep last synced edge input for the strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], {data_i, edge_i}};
      prev_q <= sync_q[STAGES-1][0];
    end
  end
  assign data_o = sync_q[STAGES-1][WIDTH:1];
  assign rise_o = sync_q[STAGES-1][0] & ~prev_q;
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: oversampled I2S receiver producing coherent L/R sample pairs
module i2s_rx_deserializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int SLOT_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] left_out,
  output logic [SAMPLE_WIDTH-1:0] right_out,
  output logic                    sample_valid,
  output logic                    frame_error
);
  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SLOT_WIDTH - 1);
  logic [1:0] rst_q;
  logic       rst_n_s;
  logic [1:0] io_s;
  logic       bclk_rise, lrclk_s, sdata_s, lr_edge;
  rx_state_t  state_q, state_d;
  channel_t   ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] lsr_q, lsr_d, rsr_q, rsr_d, left_q, left_d, right_q, right_d;
  logic lr_q, lr_d, commit_q, commit_d, err_q, err_d, valid_q, valid_d;
  // Reset asserts immediately but releases on a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n_s = rst_q[1];
  sync_edge_detect #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync (
    .clk     (clk),
    .reset_n (rst_n_s),
    .edge_i  (i2s_bclk),
    .data_i  ({i2s_sdata, i2s_lrclk}),
    .data_o  (io_s),
    .rise_o  (bclk_rise)
  );
  assign {sdata_s, lrclk_s} = io_s;
  assign lr_edge = lrclk_s != lr_q;
  // Protocol FSM: every action is qualified by a BCLK rising edge; enable low parks in IDLE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    lsr_d    = lsr_q;
    rsr_d    = rsr_q;
    lr_d     = lr_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    if (bclk_rise) begin
      lr_d = lrclk_s;
      case (state_q)
        IDLE: if (lr_edge && !lrclk_s) begin
          state_d = SKIP;
          ch_d    = CH_LEFT;
          cnt_d   = '0;
        end
        SKIP: begin
          state_d = lr_edge ? IDLE : SHIFT;
          err_d   = lr_edge;
          cnt_d   = lr_edge ? '0 : CW'(1);
        end
        SHIFT: if (lr_edge) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          lsr_d    = ch_q == CH_LEFT ? {lsr_q[SAMPLE_WIDTH-2:0], sdata_s} : lsr_q;
          rsr_d    = ch_q == CH_RIGHT ? {rsr_q[SAMPLE_WIDTH-2:0], sdata_s} : rsr_q;
          cnt_d    = cnt_q + CW'(1);
          state_d  = cnt_q == LAST_BIT ? PAD : SHIFT;
          commit_d = cnt_q == LAST_BIT && ch_q == CH_RIGHT;
        end
        PAD: if (lr_edge) begin
          state_d = SKIP;
          ch_d    = lrclk_s ? CH_RIGHT : CH_LEFT;
          cnt_d   = '0;
        end else if (cnt_q == LAST_SLOT) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      endcase
    end
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      commit_d = 1'b0;
      err_d    = 1'b0;
    end
  end
  // Both words are published together one clock after the right LSB is shifted
  always_comb begin
    valid_d = commit_q & enable;
    left_d  = valid_d ? lsr_q : left_q;
    right_d = valid_d ? rsr_q : right_q;
  end
  // State, shift and output registers
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_q     <= CH_LEFT;
      lsr_q    <= '0;
      rsr_q    <= '0;
      lr_q     <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      lsr_q    <= lsr_d;
      rsr_q    <= rsr_d;
      lr_q     <= lr_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end
  assign left_out     = left_q;
  assign right_out    = right_q;
  assign sample_valid = valid_q;
  assign frame_error  = err_q;
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb_i2s_rx_deserializer: scoreboard bench driving I2S frames and checking samples and errors
module tb_i2s_rx_deserializer;
  localparam int SW = 16, SLOT = 32, SYNC = 2;
  logic clk = 1'b0;
  logic reset_n, enable, bclk, lrclk, sdata;
  logic [SW-1:0] left_out, right_out;
  logic sample_valid, frame_error;
  int n_chk = 0, n_fail = 0, n_valid = 0, n_err = 0, n_push = 0;
  int cyc = 0, cyc_rise = 0, pos_rise = 0, exp_err = 0;
  logic [31:0] sb[$];
  int eq[$];
  logic [SW-1:0] last_l = '0, last_r = '0;

  i2s_rx_deserializer #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_sdata    (sdata),
    .left_out     (left_out),
    .right_out    (right_out),
    .sample_valid (sample_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slot position 0 is the LRCLK-edge bit, 1 the delay bit, then MSB-first data, then padding
  function automatic logic sd_at(input logic [SW-1:0] d, input int pos);
    if (pos < 2) return 1'b1;
    if (pos < 2 + SW) return d[SW + 1 - pos];
    return pos[0];
  endfunction

  task automatic bit_cycle(input logic lr, input logic sd, input int pos);
    bclk = 1'b0;
    lrclk = lr;
    sdata = sd;
    #40;
    bclk = 1'b1;
    cyc_rise = cyc;
    pos_rise = pos;
    #40;
  endtask

  task automatic send_slot(input logic lr, input logic [SW-1:0] d, input int n, input int en_off, input int en_on);
    for (int p = 0; p < n; p++) begin
      if (p == en_off) enable = 1'b0;
      if (p == en_on) enable = 1'b1;
      bit_cycle(lr, sd_at(d, p), p);
    end
  endtask

  task automatic frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    sb.push_back({l, r});
    n_push++;
    last_l = l;
    last_r = r;
    send_slot(1'b0, l, SLOT, -1, -1);
    send_slot(1'b1, r, SLOT, -1, -1);
  endtask

  // Output monitor: pops expected samples / error positions as the DUT strobes
  always @(negedge clk) begin : mon
    logic [31:0] e;
    int ep;
    if (sample_valid || frame_error) check("strobe_excl", 32'(sample_valid & frame_error), 32'd0);
    if (sample_valid) begin
      n_valid++;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("left", 32'(left_out), 32'(e[31:16]));
        check("right", 32'(right_out), 32'(e[15:0]));
        check("valid_lat", 32'(cyc - cyc_rise), 32'(SYNC + 2));
      end
    end
    if (frame_error) begin
      n_err++;
      check("err_nonempty", 32'(eq.size() > 0), 32'd1);
      if (eq.size() > 0) begin
        ep = eq.pop_front();
        check("err_pos", 32'(pos_rise), 32'(ep));
        check("err_lat", 32'(cyc - cyc_rise), 32'(SYNC + 1));
      end
    end
  end

  initial begin
    int v0;
    reset_n = 1'b0;
    enable = 1'b1;
    bclk = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    send_slot(1'b0, 16'h1234, SLOT, -1, -1);
    send_slot(1'b1, 16'h5678, SLOT, -1, -1);
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_right", 32'(right_out), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_err", 32'(frame_error), 32'd0);
    check("rst_nstrobe", 32'(n_valid + n_err), 32'd0);
    fork
      begin
        #((SLOT + 10) * 80 + 20);
        reset_n = 1'b1;
      end
    join_none
    send_slot(1'b0, 16'h4321, SLOT, -1, -1);
    send_slot(1'b1, 16'h8765, SLOT, -1, -1);
    check("rel_no_valid", 32'(n_valid), 32'd0);
    frame(16'h8001, 16'h7FFE);
    check("basic_left", 32'(left_out), 32'h8001);
    check("basic_right", 32'(right_out), 32'h7FFE);
    v0 = n_valid;
    for (int n = 0; n < 8; n++) frame(16'(n), ~16'(n));
    check("b2b_count", 32'(n_valid - v0), 32'd8);
    check("b2b_noerr", 32'(n_err), 32'(exp_err));
    eq.push_back(0);
    exp_err++;
    send_slot(1'b0, 16'hAAAA, 12, -1, -1);
    send_slot(1'b1, 16'h5555, SLOT, -1, -1);
    check("short_err", 32'(n_err), 32'(exp_err));
    check("short_left_hold", 32'(left_out), 32'(last_l));
    check("short_right_hold", 32'(right_out), 32'(last_r));
    frame(16'h1111, 16'h2222);
    eq.push_back(SLOT);
    exp_err++;
    send_slot(1'b0, 16'hBEEF, 40, -1, -1);
    send_slot(1'b1, 16'h0123, SLOT, -1, -1);
    check("long_err_once", 32'(n_err), 32'(exp_err));
    check("long_left_hold", 32'(left_out), 32'(last_l));
    frame(16'h3C3C, 16'hC3C3);
    v0 = n_valid;
    send_slot(1'b0, 16'hCAFE, SLOT, -1, -1);
    send_slot(1'b1, 16'hF00D, SLOT, 8, 24);
    check("en_no_valid", 32'(n_valid - v0), 32'd0);
    check("en_no_err", 32'(n_err), 32'(exp_err));
    check("en_left_hold", 32'(left_out), 32'(last_l));
    check("en_right_hold", 32'(right_out), 32'(last_r));
    frame(16'h0F0F, 16'hF0F0);
    #400;
    check("final_left", 32'(left_out), 32'h0F0F);
    check("final_right", 32'(right_out), 32'hF0F0);
    check("valid_total", 32'(n_valid), 32'(n_push));
    check("err_total", 32'(n_err), 32'(exp_err));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("eq_drained", 32'(eq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
    $finish;
  end
endmodule
